// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register.
// Performs a data-memory load or store with WAIT_CYCLES wait states, stalls the
// upstream pipeline while the access is in progress, and registers the results
// for write-back. All resets are synchronous, active-high.
module mem_wb_stage #(
  parameter int MEM_WORDS   = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        Memory_write_i,
  input  logic        Memory_read_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RDaddr_i,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUresult_o,
  output logic [4:0]  RDaddr_o,
  output logic        stall_o
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  // Counter only ever holds WAIT_CYCLES-1 down to 0; keep it at least one bit wide.
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // Instruction held while the access waits; upstream inputs are ignored in BUSY.
  logic        hold_reg_write;
  logic        hold_mem_to_reg;
  logic        hold_mem_write;
  logic        hold_mem_read;
  logic [31:0] hold_addr;
  logic [31:0] hold_wdata;
  logic [4:0]  hold_rd;

  logic [31:0] mem [MEM_WORDS];

  logic req;
  logic load_hold;
  logic use_hold;
  logic bubble;
  logic complete;

  logic             sel_reg_write;
  logic             sel_mem_to_reg;
  logic             sel_mem_write;
  logic             sel_mem_read;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [4:0]       sel_rd;
  logic [IDX_W-1:0] sel_idx;
  logic             mem_we;
  logic [31:0]      load_data;

  assign req = Memory_read_i | Memory_write_i;

  // Next-state logic: decides stall, bubble insertion and access completion.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_next = state;
    cnt_next   = cnt;
    stall_o    = 1'b0;
    load_hold  = 1'b0;
    use_hold   = 1'b0;
    bubble     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            stall_o    = 1'b1;
            load_hold  = 1'b1;
            bubble     = 1'b1;
            state_next = BUSY;
            cnt_next   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        use_hold = 1'b1;
        if (cnt != '0) begin
          stall_o  = 1'b1;
          bubble   = 1'b1;
          cnt_next = cnt - CNT_W'(1);
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand select: the latched instruction in BUSY, the live inputs otherwise.
  always_comb begin
    sel_reg_write  = use_hold ? hold_reg_write  : RegWrite_i;
    sel_mem_to_reg = use_hold ? hold_mem_to_reg : MemtoReg_i;
    sel_mem_write  = use_hold ? hold_mem_write  : Memory_write_i;
    sel_mem_read   = use_hold ? hold_mem_read   : Memory_read_i;
    sel_addr       = use_hold ? hold_addr       : ALUresult_i;
    sel_wdata      = use_hold ? hold_wdata      : WriteData_i;
    sel_rd         = use_hold ? hold_rd         : RDaddr_i;
    // Byte offset and bits above the array are dropped, so addresses wrap.
    sel_idx        = sel_addr[IDX_W+1:2];
    mem_we         = complete & sel_mem_write;
    // A store wins when both request bits are set, and then returns zero data.
    load_data      = (complete & sel_mem_read & ~sel_mem_write) ? mem[sel_idx] : '0;
  end

  // Data memory write port; a reset in the completing cycle drops the store.
  always_ff @(posedge clk_i) begin
    // NOTE: the array is deliberately not reset so it maps onto plain RAM; contents survive rst_i.
    if (!rst_i && mem_we) begin
      mem[sel_idx] <= sel_wdata;
    end
  end

  // FSM, wait counter, holding registers and MEM/WB output register.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state           <= IDLE;
      cnt             <= '0;
      hold_reg_write  <= 1'b0;
      hold_mem_to_reg <= 1'b0;
      hold_mem_write  <= 1'b0;
      hold_mem_read   <= 1'b0;
      hold_addr       <= '0;
      hold_wdata      <= '0;
      hold_rd         <= '0;
      RegWrite_o      <= 1'b0;
      MemtoReg_o      <= 1'b0;
      ReadData_o      <= '0;
      ALUresult_o     <= '0;
      RDaddr_o        <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (load_hold) begin
        hold_reg_write  <= RegWrite_i;
        hold_mem_to_reg <= MemtoReg_i;
        hold_mem_write  <= Memory_write_i;
        hold_mem_read   <= Memory_read_i;
        hold_addr       <= ALUresult_i;
        hold_wdata      <= WriteData_i;
        hold_rd         <= RDaddr_i;
      end
      if (bubble) begin
        RegWrite_o  <= 1'b0;
        MemtoReg_o  <= 1'b0;
        ReadData_o  <= '0;
        ALUresult_o <= '0;
        RDaddr_o    <= '0;
      end else begin
        RegWrite_o  <= sel_reg_write;
        MemtoReg_o  <= sel_mem_to_reg;
        ReadData_o  <= load_data;
        ALUresult_o <= sel_addr;
        RDaddr_o    <= sel_rd;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: one instance with two wait states and
// one single-cycle instance, each checked every cycle against an
// instruction-level model, plus directed literal checks.
module tb_mem_wb_stage;

  localparam int WAIT_OF [2] = '{2, 0};

  logic clk;
  logic rst;

  logic        rw   [2];
  logic        mtr  [2];
  logic        mw   [2];
  logic        mr   [2];
  logic [31:0] alu  [2];
  logic [31:0] wd   [2];
  logic [4:0]  rd   [2];

  logic        o_rw    [2];
  logic        o_mtr   [2];
  logic [31:0] o_data  [2];
  logic [31:0] o_alu   [2];
  logic [4:0]  o_rd    [2];
  logic        stall   [2];

  mem_wb_stage #(.MEM_WORDS(32), .WAIT_CYCLES(2)) dut_wait (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(rw[0]), .MemtoReg_i(mtr[0]),
    .Memory_write_i(mw[0]), .Memory_read_i(mr[0]),
    .ALUresult_i(alu[0]), .WriteData_i(wd[0]), .RDaddr_i(rd[0]),
    .RegWrite_o(o_rw[0]), .MemtoReg_o(o_mtr[0]),
    .ReadData_o(o_data[0]), .ALUresult_o(o_alu[0]), .RDaddr_o(o_rd[0]),
    .stall_o(stall[0])
  );

  mem_wb_stage #(.MEM_WORDS(32), .WAIT_CYCLES(0)) dut_fast (
    .clk_i(clk), .rst_i(rst),
    .RegWrite_i(rw[1]), .MemtoReg_i(mtr[1]),
    .Memory_write_i(mw[1]), .Memory_read_i(mr[1]),
    .ALUresult_i(alu[1]), .WriteData_i(wd[1]), .RDaddr_i(rd[1]),
    .RegWrite_o(o_rw[1]), .MemtoReg_o(o_mtr[1]),
    .ReadData_o(o_data[1]), .ALUresult_o(o_alu[1]), .RDaddr_o(o_rd[1]),
    .stall_o(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- instruction-level model ----------------
  // age = cycles the current memory instruction has already occupied the stage.
  int          age    [2];
  logic [31:0] m_mem  [2][32];
  logic        h_rw   [2];
  logic        h_mtr  [2];
  logic        h_mw   [2];
  logic [31:0] h_alu  [2];
  logic [31:0] h_wd   [2];
  logic [4:0]  h_rd   [2];
  logic        e_rw   [2];
  logic        e_mtr  [2];
  logic [31:0] e_data [2];
  logic [31:0] e_alu  [2];
  logic [4:0]  e_rd   [2];

  // A memory instruction occupies WAIT+1 cycles and stalls on all but the last.
  function automatic bit exp_stall(input int k);
    logic req;
    req = mr[k] | mw[k];
    return (age[k] > 0 || req) && age[k] < WAIT_OF[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        age[k] = 0;
        e_rw[k] = 0; e_mtr[k] = 0; e_data[k] = 0; e_alu[k] = 0; e_rd[k] = 0;
      end else if (age[k] == 0 && !(mr[k] | mw[k])) begin
        e_rw[k] = rw[k]; e_mtr[k] = mtr[k]; e_data[k] = 0;
        e_alu[k] = alu[k]; e_rd[k] = rd[k];
      end else begin
        if (age[k] == 0) begin
          h_rw[k] = rw[k]; h_mtr[k] = mtr[k]; h_mw[k] = mw[k];
          h_alu[k] = alu[k]; h_wd[k] = wd[k]; h_rd[k] = rd[k];
        end
        if (age[k] < WAIT_OF[k]) begin
          age[k]++;
          e_rw[k] = 0; e_mtr[k] = 0; e_data[k] = 0; e_alu[k] = 0; e_rd[k] = 0;
        end else begin
          e_rw[k] = h_rw[k]; e_mtr[k] = h_mtr[k];
          e_alu[k] = h_alu[k]; e_rd[k] = h_rd[k];
          if (h_mw[k]) begin
            m_mem[k][h_alu[k][6:2]] = h_wd[k];
            e_data[k] = 0;
          end else begin
            e_data[k] = m_mem[k][h_alu[k][6:2]];
          end
          age[k] = 0;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("k%0d_stall", k), stall[k], exp_stall(k));
        check($sformatf("k%0d_regwrite", k), o_rw[k], e_rw[k]);
        check($sformatf("k%0d_memtoreg", k), o_mtr[k], e_mtr[k]);
        check($sformatf("k%0d_readdata", k), o_data[k], e_data[k]);
        check($sformatf("k%0d_aluresult", k), o_alu[k], e_alu[k]);
        check($sformatf("k%0d_rdaddr", k), o_rd[k], e_rd[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input int k, input bit rw_v, input bit mtr_v, input bit mw_v,
                        input bit mr_v, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r);
    rw[k] = rw_v; mtr[k] = mtr_v; mw[k] = mw_v; mr[k] = mr_v;
    alu[k] = a; wd[k] = d; rd[k] = r;
  endtask

  // Present one instruction, hold it until accepted (or scramble inputs while the
  // stage is busy), and return at posedge+1 after the completing edge.
  task automatic op(input int k, input bit rw_v, input bit mtr_v, input bit mw_v,
                    input bit mr_v, input logic [31:0] a, input logic [31:0] d,
                    input logic [4:0] r, input bit scr);
    bit done;
    int n_stall;
    done = 1'b0;
    n_stall = 0;
    set_in(k, rw_v, mtr_v, mw_v, mr_v, a, d, r);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      done = !exp_stall(k);
      if (stall[k]) n_stall++;
      @(posedge clk);
      #1;
      if (done) break;
      if (scr) set_in(k, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom, $urandom, 5'($urandom));
    end
    check($sformatf("k%0d_accept", k), 32'(done), 32'd1);
    check($sformatf("k%0d_stall_cycles", k), n_stall, (mw_v | mr_v) ? WAIT_OF[k] : 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) set_in(k, 0, 0, 0, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_regwrite", o_rw[0], 0);
    check("reset_aluresult", o_alu[0], 0);
    check("reset_stall", stall[0], 0);

    // 1: pass-through of a non-memory instruction
    op(0, 1, 0, 0, 0, 32'h0000_0011, 32'h0, 5'd5, 0);
    check("t1_regwrite", o_rw[0], 1);
    check("t1_aluresult", o_alu[0], 32'h11);
    check("t1_rdaddr", o_rd[0], 5);
    check("t1_readdata", o_data[0], 0);

    // 2: store then load with two wait states; inputs scrambled during the load wait
    op(0, 0, 0, 1, 0, 32'h8, 32'hDEADBEEF, 5'd0, 0);
    check("t2_store_readdata", o_data[0], 0);
    op(0, 1, 1, 0, 1, 32'h8, 32'h0, 5'd9, 1);
    check("t2_load_readdata", o_data[0], 32'hDEADBEEF);
    check("t2_load_rdaddr", o_rd[0], 9);
    check("t2_load_regwrite", o_rw[0], 1);
    check("t2_load_memtoreg", o_mtr[0], 1);
    check("t2_load_aluresult", o_alu[0], 32'h8);

    // 3: wrap-around and misaligned address hit the same word
    op(0, 0, 0, 1, 0, 32'h4, 32'h12345678, 5'd0, 0);
    op(0, 1, 1, 0, 1, 32'h86, 32'h0, 5'd7, 0);
    check("t3_wrap_readdata", o_data[0], 32'h12345678);
    check("t3_wrap_aluresult", o_alu[0], 32'h86);

    // 4: read and write both high behave as a store
    op(0, 1, 0, 1, 1, 32'hC, 32'hA5A5A5A5, 5'd2, 0);
    check("t4_both_readdata", o_data[0], 0);
    op(0, 1, 1, 0, 1, 32'hC, 32'h0, 5'd3, 0);
    check("t4_load_readdata", o_data[0], 32'hA5A5A5A5);

    // 5: reset in the final busy cycle drops the store
    op(0, 0, 0, 1, 0, 32'h10, 32'h2222, 5'd0, 0);
    set_in(0, 0, 0, 1, 0, 32'h10, 32'h1111, 5'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check("t5_stall_after_reset", stall[0], 0);
    check("t5_readdata_after_reset", o_data[0], 0);
    @(posedge clk);
    #1;
    op(0, 1, 1, 0, 1, 32'h10, 32'h0, 5'd4, 0);
    check("t5_load_readdata", o_data[0], 32'h2222);

    // 6: single-cycle instance, store then immediate load
    op(1, 0, 0, 1, 0, 32'h14, 32'hCAFEF00D, 5'd0, 0);
    check("t6_store_readdata", o_data[1], 0);
    op(1, 1, 1, 0, 1, 32'h14, 32'h0, 5'd6, 0);
    check("t6_load_readdata", o_data[1], 32'hCAFEF00D);
    check("t6_load_rdaddr", o_rd[1], 6);
    op(1, 1, 0, 0, 0, 32'hFFFF_0001, 32'h0, 5'd31, 0);
    check("t6_pass_aluresult", o_alu[1], 32'hFFFF_0001);

    set_in(0, 0, 0, 0, 0, '0, '0, '0);
    set_in(1, 0, 0, 0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
- Consumes that register's outputs: control bits, ALU result used as the address, store data, and destination register.
- Performs a data-memory access with a configurable wait-state count. Raises stall_o to hold the upstream pipeline during the wait.
- Registers the results for write-back.

Parameters:
- MEM_WORDS, 32: data memory depth in 32-bit words (power of two).
- WAIT_CYCLES, 2: extra cycles a load/store occupies (0 = single-cycle access).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- RegWrite_i  in  1  write-back enable from EX/MEM
- MemtoReg_i  in  1  select memory data for write-back
- Memory_write_i  in  1  store request
- Memory_read_i  in  1  load request
- ALUresult_i  in  32  byte address / ALU result
- WriteData_i  in  32  store data
- RDaddr_i  in  5  destination register
- RegWrite_o  out  1  registered write-back enable
- MemtoReg_o  out  1  registered select
- ReadData_o  out  32  registered load data
- ALUresult_o  out  32  registered ALU result
- RDaddr_o  out  5  registered destination
- stall_o  out  1  combinational; upstream must hold its registers while high

Behaviour:
- Interface: one clock, clk_i. rst_i is synchronous and active-high.
- Reset:
  - All registered outputs go to 0. FSM goes to IDLE. Counter goes to 0.
  - Memory contents are not cleared.
  - Reset mid-access aborts it: a pending store is dropped, and stall_o is 0 in the cycle after reset.
- Addressing:
  - Word index = ALUresult_i[log2(MEM_WORDS)+1:2].
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo MEM_WORDS*4.
- Access request: req = Memory_read_i | Memory_write_i.
  - If both are high, the cycle is a store. ReadData_o is then 0.
- FSM states: IDLE, BUSY.
- IDLE, no req:
  - Non-memory instruction. Pass-through with 1-cycle latency: outputs register the inputs. ReadData_o = 0.
- IDLE, req, WAIT_CYCLES=0:
  - At the edge: store writes memory, or load captures mem[index] into ReadData_o. Control/addr/RD are registered.
  - stall_o = 0.
- IDLE, req, WAIT_CYCLES>0:
  - stall_o = 1 this cycle.
  - Latch address, store data, RDaddr and control into internal holding registers.
  - Go to BUSY with cnt = WAIT_CYCLES-1.
  - Output register loads a bubble: RegWrite_o=0, MemtoReg_o=0, RDaddr_o=0, ReadData_o=0, ALUresult_o=0.
- BUSY, cnt≠0:
  - stall_o = 1. cnt decrements. Output register keeps loading the bubble.
  - Inputs are ignored; the latched values are used.
- BUSY, cnt=0:
  - stall_o = 0.
  - At the edge: perform the store, or capture load data. Outputs load the latched control/addr/RD with the read data. Return to IDLE.
- Timing:
  - Total occupancy = WAIT_CYCLES+1 cycles.
  - Write-back data appears one cycle after the completing edge.
- Back-to-back accesses: a new req seen in IDLE on the cycle after completion starts a new access. There is no dead cycle beyond the wait states.
- Loads read memory state before any same-edge store. Only one access is in flight, so a read-after-write conflict is impossible.
- ALUresult_o always carries the full 32-bit ALU result, unmodified.

Test Plan:
1. Reset then pass-through: RegWrite_i=1, MemtoReg_i=0, ALUresult_i=0x0000_0011, RDaddr_i=5, no req. Next cycle: RegWrite_o=1, ALUresult_o=0x11, RDaddr_o=5, ReadData_o=0, stall_o=0 throughout.
2. Store then load, WAIT_CYCLES=2:
   - Store 0xDEADBEEF to 0x8. stall_o is high for 2 cycles; outputs are a bubble during the wait.
   - Then load 0x8 to RD=9 with MemtoReg=1. After 3 cycles: ReadData_o=0xDEADBEEF, RDaddr_o=9, RegWrite_o=1.
3. Wrap and misalign, MEM_WORDS=32: store 0x12345678 at 0x4, then load 0x86. Index 1 → ReadData_o=0x12345678.
4. Both read and write high: address 0xC, data 0xA5A5A5A5. Memory is written and ReadData_o=0. A later load of 0xC returns 0xA5A5A5A5.
5. Reset mid-access: start a store of 0x1111 to 0x10, assert rst_i in the BUSY cycle. FSM returns to IDLE, stall_o=0, and a load of 0x10 returns the prior contents (not 0x1111).
6. WAIT_CYCLES=0 build: store then immediate load to the same address on consecutive cycles. stall_o is never high, and the load returns the stored value one cycle later.
